ex_mem_stage: RTL and testbench

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_pkg.sv | 29 ++
 rtl/pipe_skid_reg.sv | 20 ++
 rtl/ex_mem_stage.sv | 111 +++++++++++
 tb/tb_ex_mem_stage.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pkg.sv
// Shared types for the EX/MEM pipeline stage: control bundle layout and
// occupancy-state encoding.
package ex_mem_pkg;

    // Control bundle is {reg_write, mem_read, mem_write, mem_to_reg}, MSB first.
    localparam int CTRL_BITS       = 4;
    localparam int CTRL_REG_WRITE  = 3;
    localparam int CTRL_MEM_READ   = 2;
    localparam int CTRL_MEM_WRITE  = 1;
    localparam int CTRL_MEM_TO_REG = 0;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ctrl_t;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    typedef enum logic [1:0] {
        EMPTY = ST_EMPTY,
        ONE   = ST_ONE,
        TWO   = ST_TWO
    } state_t;

endpackage

// File: rtl/pipe_skid_reg.sv
// Falling-edge register with load enable and asynchronous clear; used for
// both the main and skid slots of the EX/MEM stage.
module pipe_skid_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(negedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a one-entry skid buffer, clocked on the
// falling edge. Define EX_MEM_STAGE_FWD_EN to add the hazard-unit forwarding ports.
module ex_mem_stage
    import ex_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [REG_W-1:0]  in_rt,
    input  logic [DATA_W-1:0] in_dato_b,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_alu,
    output logic [REG_W-1:0]  out_rd,
    output logic [REG_W-1:0]  out_rt,
    output logic [DATA_W-1:0] out_dato_b,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef EX_MEM_STAGE_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_reg,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    localparam int ENT_W = 2*DATA_W + 2*REG_W + CTRL_W;

    state_t             state;
    logic [ENT_W-1:0]   in_entry, main_d, main_q, skid_q;
    logic               xfer_in, xfer_out, main_en, skid_en;

    assign in_entry = {in_alu, in_rd, in_rt, in_dato_b, in_ctrl};
    assign xfer_in  = in_valid & in_ready & ~flush;
    assign xfer_out = out_valid & out_ready;

    // Main reloads from the skid when draining TWO, otherwise from the input.
    assign main_en = ~flush & (((state == EMPTY) & xfer_in) |
                               ((state == ONE) & xfer_in & xfer_out) |
                               ((state == TWO) & xfer_out));
    assign skid_en = ~flush & (state == ONE) & xfer_in & ~xfer_out;
    assign main_d  = (state == TWO) ? skid_q : in_entry;

    pipe_skid_reg #(.W(ENT_W)) u_main (
        .clk (clk),
        .rst (rst),
        .en  (main_en),
        .d   (main_d),
        .q   (main_q)
    );

    pipe_skid_reg #(.W(ENT_W)) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (skid_en),
        .d   (in_entry),
        .q   (skid_q)
    );

    assign {out_alu, out_rd, out_rt, out_dato_b, out_ctrl} = main_q;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else if (flush) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                EMPTY: if (xfer_in) begin
                    state     <= ONE;
                    out_valid <= 1'b1;
                end
                ONE: if (xfer_in && !xfer_out) begin
                    state    <= TWO;
                    in_ready <= 1'b0;
                end else if (!xfer_in && xfer_out) begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                end
                TWO: if (xfer_out) begin
                    state    <= ONE;
                    in_ready <= 1'b1;
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef EX_MEM_STAGE_FWD_EN
    assign fwd_valid = out_valid & out_ctrl[CTRL_REG_WRITE] & (out_rd != '0);
    assign fwd_reg   = out_rd;
    assign fwd_data  = out_alu;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed and randomised checks of ex_mem_stage against hand values and a
// two-deep FIFO reference model.
module tb_ex_mem_stage;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CTRL_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_ready, flush, out_valid, out_ready;
    logic [DATA_W-1:0] in_alu, in_dato_b, out_alu, out_dato_b;
    logic [REG_W-1:0]  in_rd, in_rt, out_rd, out_rt;
    logic [CTRL_W-1:0] in_ctrl, out_ctrl;
`ifdef EX_MEM_STAGE_FWD_EN
    logic              fwd_valid;
    logic [REG_W-1:0]  fwd_reg;
    logic [DATA_W-1:0] fwd_data;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_mem_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CTRL_W(CTRL_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_alu     (in_alu),
        .in_rd      (in_rd),
        .in_rt      (in_rt),
        .in_dato_b  (in_dato_b),
        .in_ctrl    (in_ctrl),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_alu    (out_alu),
        .out_rd     (out_rd),
        .out_rt     (out_rt),
        .out_dato_b (out_dato_b),
        .out_ctrl   (out_ctrl)
`ifdef EX_MEM_STAGE_FWD_EN
        ,
        .fwd_valid  (fwd_valid),
        .fwd_reg    (fwd_reg),
        .fwd_data   (fwd_data)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the falling edge; outputs are sampled there too.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] alu);
        in_valid = v;
        in_alu   = alu;
    endtask

    typedef logic [2*DATA_W+2*REG_W+CTRL_W-1:0] ent_t;
    ent_t q[$];

    function automatic ent_t in_ent();
        return {in_alu, in_rd, in_rt, in_dato_b, in_ctrl};
    endfunction

    function automatic ent_t out_ent();
        return {out_alu, out_rd, out_rt, out_dato_b, out_ctrl};
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_alu = 32'hFFFF; in_rd = 5'd3; in_rt = 5'd4;
        in_dato_b = 32'h55; in_ctrl = 4'hF;
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_ent", out_ent(), 0);
        step();
        chk("rst_hold_valid", out_valid, 0);
        rst = 1'b0;

        // Streaming, no bubble
        in_rd = 5'd1; in_rt = 5'd2; in_dato_b = 32'h0; in_ctrl = 4'h0;
        out_ready = 1'b1;
        drive(1, 1); step();
        chk("stream1_valid", out_valid, 1);
        chk("stream1_alu", out_alu, 1);
        drive(1, 2); step();
        chk("stream2_alu", out_alu, 2);
        drive(1, 3); step();
        chk("stream3_alu", out_alu, 3);
        chk("stream3_ready", in_ready, 1);
        drive(0, 0); step();
        chk("stream_drain", out_valid, 0);

        // Backpressure
        out_ready = 1'b0;
        drive(1, 32'hA); step();
        chk("bp_a_alu", out_alu, 32'hA);
        chk("bp_a_ready", in_ready, 1);
        drive(1, 32'hB); step();
        chk("bp_two_ready", in_ready, 0);
        chk("bp_two_alu", out_alu, 32'hA);
        drive(0, 0); step();
        chk("bp_hold_alu", out_alu, 32'hA);
        chk("bp_hold_valid", out_valid, 1);
        out_ready = 1'b1; step();
        chk("bp_b_alu", out_alu, 32'hB);
        chk("bp_b_ready", in_ready, 1);
        step();
        chk("bp_empty", out_valid, 0);

        // Flush from TWO with 0xC offered
        out_ready = 1'b0;
        drive(1, 32'hA); step();
        drive(1, 32'hB); step();
        chk("fl_two", in_ready, 0);
        drive(1, 32'hC); flush = 1'b1; step();
        chk("fl_valid", out_valid, 0);
        chk("fl_ready", in_ready, 1);
        flush = 1'b0; drive(0, 0); step();
        chk("fl_still_empty", out_valid, 0);
        chk("fl_no_c", out_alu == 32'hC, 0);

        // Bit-exact fields
        out_ready = 1'b1;
        in_rd = 5'h1F; in_rt = 5'h0A; in_dato_b = 32'hDEADBEEF; in_ctrl = 4'b1010;
        drive(1, 32'h8000_0001); step();
        chk("fields", out_ent(), {32'h8000_0001, 5'h1F, 5'h0A, 32'hDEADBEEF, 4'b1010});
        drive(0, 0); step();

        // Reset mid-transfer discards both slots
        out_ready = 1'b0;
        drive(1, 32'h11); step();
        drive(1, 32'h22); step();
        #2 rst = 1'b1; #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_ent", out_ent(), 0);
        rst = 1'b0;
        drive(0, 0); out_ready = 1'b1; step();
        chk("post_rst_empty", out_valid, 0);

`ifdef EX_MEM_STAGE_FWD_EN
        out_ready = 1'b0;
        in_ctrl = 4'b1000; in_rd = 5'd5;
        drive(1, 32'h1234); step();
        chk("fwd_valid", fwd_valid, 1);
        chk("fwd_reg", fwd_reg, 5);
        chk("fwd_data", fwd_data, 32'h1234);
        flush = 1'b1; drive(0, 0); step();
        chk("fwd_flushed", fwd_valid, 0);
        flush = 1'b0; in_rd = 5'd0; drive(1, 32'h1234); step();
        chk("fwd_rd0", fwd_valid, 0);
        flush = 1'b1; drive(0, 0); step();
        flush = 1'b0; in_rd = 5'd5; in_ctrl = 4'b0111; drive(1, 32'h1234); step();
        chk("fwd_nowrite", fwd_valid, 0);
        flush = 1'b1; drive(0, 0); step();
        flush = 1'b0;
`endif

        // Random stall/flush against the reference FIFO
        q.delete();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic rdy_m, vld_m;
            in_valid  = ($urandom_range(99) < 70);
            out_ready = ($urandom_range(99) < 55);
            flush     = ($urandom_range(99) < 2);
            in_alu    = $urandom;
            in_dato_b = $urandom;
            in_rd     = REG_W'($urandom);
            in_rt     = REG_W'($urandom);
            in_ctrl   = CTRL_W'($urandom);
            rdy_m = (q.size() < 2);
            vld_m = (q.size() > 0);
            chk("rnd_ready", in_ready, rdy_m);
            chk("rnd_valid", out_valid, vld_m);
            if (vld_m)
                chk("rnd_data", out_ent(), q[0]);
            if (flush) begin
                q.delete();
            end else begin
                ent_t e;
                e = in_ent();
                if (vld_m && out_ready) void'(q.pop_front());
                if (in_valid && rdy_m) q.push_back(e);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
